// File: rtl/thresh_pkg.sv
// Shared types and widths for the thresholding controller (MemP words -> MemB bytes).
// Optional THRESH_INVERT_EN macro (used elsewhere) adds inverted mapping.
package thresh_pkg;
  localparam int MP_AW          = 15;
  localparam int MB_AW          = 17;
  localparam int MP_DW          = 32;
  localparam int MB_DW          = 8;
  localparam int NWORDS_DEFAULT = 19200;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR0, WR1, WR2, WR3, FIN} state_t;

  // Big-endian byte pick: k=0 is the most significant byte.
  function automatic logic [MB_DW-1:0] src_byte(input logic [MP_DW-1:0] word,
                                                input logic [1:0]       k);
    logic [MB_DW-1:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction
endpackage

// File: rtl/thresh_if.sv
// Go/Done handshake plus MemP read and MemB write ports of the thresholding controller.
// master = controller side, slave = environment side.
interface thresh_if;
  import thresh_pkg::*;

  logic             Go;
  logic             Done;
  logic [MB_DW-1:0] Thr;
  logic [MP_AW-1:0] MP_Addr15;
  logic             MP_en;
  logic [MP_DW-1:0] MP_do32;
  logic [MB_AW-1:0] MB_Addr17;
  logic             MB_en;
  logic             MB_we;
  logic [MB_DW-1:0] MB_di8;

  modport master (
    input  Go, Thr, MP_do32,
    output Done, MP_Addr15, MP_en, MB_Addr17, MB_en, MB_we, MB_di8
  );

  modport slave (
    output Go, Thr, MP_do32,
    input  Done, MP_Addr15, MP_en, MB_Addr17, MB_en, MB_we, MB_di8
  );
endinterface

// File: rtl/thresh_cmp.sv
// Combinational pixel compare: PIX_HI when pix > thr, else zero.
// With THRESH_INVERT_EN an extra inv input flips the mapping (PIX_HI when pix <= thr).
module thresh_cmp
  import thresh_pkg::*;
#(
  parameter logic [7:0] PIX_HI = 8'hFF
) (
  input  logic [MB_DW-1:0] pix,
  input  logic [MB_DW-1:0] thr,
`ifdef THRESH_INVERT_EN
  input  logic             inv,
`endif
  output logic [MB_DW-1:0] pix_out
);
  logic above;
  assign above = (pix > thr);

`ifdef THRESH_INVERT_EN
  assign pix_out = (above ^ inv) ? PIX_HI : '0;
`else
  assign pix_out = above ? PIX_HI : '0;
`endif
endmodule

// File: rtl/thresh_ctrl.sv
// Frame thresholder: reads NWORDS 32-bit MemP words, writes 4 thresholded bytes each to MemB.
// Define THRESH_INVERT_EN to add the Inv port (inverted pixel mapping).
module thresh_ctrl
  import thresh_pkg::*;
#(
  parameter int         NWORDS = NWORDS_DEFAULT,
  parameter logic [7:0] PIX_HI = 8'hFF
) (
  input  logic     Clk,
  input  logic     Rst,
`ifdef THRESH_INVERT_EN
  input  logic     Inv,
`endif
  thresh_if.master bus
);
  state_t           state_q, state_d;
  logic [MP_AW-1:0] w_q, w_d;
  logic [MB_DW-1:0] thr_q, thr_d;
  logic [MP_DW-1:0] hold_q, hold_d;
  logic             done_q, done_d;
`ifdef THRESH_INVERT_EN
  logic             inv_q, inv_d;
`endif
  logic [1:0]       k_sel;
  logic [MB_DW-1:0] pix_out;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      thr_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
`ifdef THRESH_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      thr_q   <= thr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef THRESH_INVERT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    thr_d   = thr_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
`ifdef THRESH_INVERT_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE, FIN: begin
        // Done is registered, so it rises one cycle after FIN is entered.
        done_d = (state_q == FIN) && !bus.Go;
        if (bus.Go) begin
          thr_d   = bus.Thr;
`ifdef THRESH_INVERT_EN
          inv_d   = Inv;
`endif
          w_d     = '0;
          state_d = RD;
        end
      end
      RD:   state_d = WAIT;
      WAIT: begin
        hold_d  = bus.MP_do32;
        state_d = WR0;
      end
      WR0:  state_d = WR1;
      WR1:  state_d = WR2;
      WR2:  state_d = WR3;
      WR3: begin
        if (w_q == MP_AW'(NWORDS - 1)) begin
          state_d = FIN;
        end else begin
          w_d     = w_q + MP_AW'(1);
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_sel = 2'd0;
    case (state_q)
      WR1:     k_sel = 2'd1;
      WR2:     k_sel = 2'd2;
      WR3:     k_sel = 2'd3;
      default: k_sel = 2'd0;
    endcase
  end

  thresh_cmp #(.PIX_HI(PIX_HI)) u_cmp (
    .pix     (src_byte(hold_q, k_sel)),
    .thr     (thr_q),
`ifdef THRESH_INVERT_EN
    .inv     (inv_q),
`endif
    .pix_out (pix_out)
  );

  // Outputs decode registered state only; Rst forces them quiet in the reset cycle.
  always_comb begin
    bus.Done      = done_q && !Rst;
    bus.MP_en     = 1'b0;
    bus.MP_Addr15 = '0;
    bus.MB_en     = 1'b0;
    bus.MB_we     = 1'b0;
    bus.MB_Addr17 = '0;
    bus.MB_di8    = '0;
    if (!Rst) begin
      case (state_q)
        RD: begin
          bus.MP_en     = 1'b1;
          bus.MP_Addr15 = w_q;
        end
        WR0, WR1, WR2, WR3: begin
          bus.MB_en     = 1'b1;
          bus.MB_we     = 1'b1;
          bus.MB_Addr17 = {w_q, k_sel};
          bus.MB_di8    = pix_out;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_thresh_ctrl.sv
// Directed bench for thresh_ctrl with a MemB write scoreboard (reduced frame size NW).
// Define THRESH_INVERT_EN to also exercise the Inv mapping.
module tb_thresh_ctrl;
  import thresh_pkg::*;

  localparam int NW = 8;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        inv_in;
  logic [31:0] mem_p [NW];
  wr_t         sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          t0;
  int          guard;

  thresh_if bus ();

  thresh_ctrl #(.NWORDS(NW), .PIX_HI(8'hFF)) dut (
    .Clk (Clk),
    .Rst (Rst),
`ifdef THRESH_INVERT_EN
    .Inv (inv_in),
`endif
    .bus (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // MemP model: registered read, data valid the cycle after MP_en.
  always @(posedge Clk) begin
    if (bus.MP_en === 1'b1) bus.MP_do32 <= mem_p[bus.MP_Addr15[2:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every MemB write.
  always @(negedge Clk) begin
    if (bus.MB_en === 1'b1 && bus.MB_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(bus.MB_Addr17), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("mb_addr", 32'(bus.MB_Addr17), 32'(e.addr));
        chk("mb_data", 32'(bus.MB_di8), 32'(e.data));
      end
    end
  end

  function automatic logic [7:0] model_pix(input logic [7:0] b, input logic [7:0] thr,
                                           input logic inv);
    return ((b > thr) != inv) ? 8'hFF : 8'h00;
  endfunction

  task automatic push_range(input logic [7:0] thr, input logic inv,
                            input int first, input int last);
    for (int i = first; i < last; i++) begin
      logic [31:0] word;
      wr_t         e;
      word   = mem_p[i / 4];
      e.addr = 17'(i);
      e.data = model_pix(word[31 - 8 * (i % 4) -: 8], thr, inv);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_lit(input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = 17'(addr);
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Go pulse; the expectations must already be queued.
  task automatic go(input logic [7:0] thr, input logic inv, output int t_acc);
    bus.Thr = thr;
    inv_in  = inv;
    bus.Go  = 1'b1;
    tick();
    bus.Go  = 1'b0;
    t_acc   = cyc;
  endtask

  task automatic wait_done(input int t_acc, input string tag);
    int g;
    g = 0;
    while (bus.Done !== 1'b1 && g < 2000) begin
      tick();
      g++;
    end
    chk({tag, "_latency"}, 32'(cyc - t_acc), 32'(6 * NW + 1));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NW; i++) mem_p[i] = $urandom();
  endtask

  initial begin
    Rst         = 1'b1;
    inv_in      = 1'b0;
    bus.Go      = 1'b0;
    bus.Thr     = 8'h00;
    bus.MP_do32 = '0;
    randomize_mem();
    repeat (3) tick();

    // Reset state
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_mp_en", 32'(bus.MP_en), 32'd0);
    chk("rst_mb_en", 32'(bus.MB_en), 32'd0);
    chk("rst_mb_we", 32'(bus.MB_we), 32'd0);
    chk("rst_mp_addr", 32'(bus.MP_Addr15), 32'd0);
    chk("rst_mb_addr", 32'(bus.MB_Addr17), 32'd0);
    chk("rst_mb_data", 32'(bus.MB_di8), 32'd0);

    // Rst beats Go in the same cycle
    bus.Go = 1'b1;
    tick();
    Rst    = 1'b0;
    bus.Go = 1'b0;
    tick();
    chk("rst_prio_mp_en_a", 32'(bus.MP_en), 32'd0);
    tick();
    chk("rst_prio_mp_en_b", 32'(bus.MP_en), 32'd0);

    // Small vector: explicit bytes for words 0..1
    mem_p[0] = 32'h00FF7F80;
    mem_p[1] = 32'h01020304;
    push_lit(0, 8'h00); push_lit(1, 8'hFF); push_lit(2, 8'h00); push_lit(3, 8'hFF);
    push_lit(4, 8'h00); push_lit(5, 8'h00); push_lit(6, 8'h00); push_lit(7, 8'h00);
    push_range(8'h7F, 1'b0, 8, 4 * NW);
    go(8'h7F, 1'b0, t0);
    wait_done(t0, "vec_small");

    // Random frame, Thr=80
    randomize_mem();
    push_range(8'h80, 1'b0, 0, 4 * NW);
    go(8'h80, 1'b0, t0);
    chk("fin_go_done_drop", 32'(bus.Done), 32'd0);
    wait_done(t0, "rand_frame");

    // Go with new Thr during word 5 must be ignored
    randomize_mem();
    push_range(8'h80, 1'b0, 0, 4 * NW);
    go(8'h80, 1'b0, t0);
    guard = 0;
    while (!(bus.MP_en === 1'b1 && bus.MP_Addr15 === 15'd5) && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_word5", 32'(bus.MP_Addr15), 32'd5);
    bus.Go  = 1'b1;
    bus.Thr = 8'h00;
    repeat (3) tick();
    bus.Go  = 1'b0;
    wait_done(t0, "go_ignored");

    // Reset in WR2 of word 3
    randomize_mem();
    push_range(8'h80, 1'b0, 0, 4 * 3 + 2);
    go(8'h80, 1'b0, t0);
    guard = 0;
    while (!(bus.MB_en === 1'b1 && bus.MB_Addr17 === 17'd14) && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_w3_wr2", 32'(bus.MB_Addr17), 32'd14);
    Rst = 1'b1;
    tick();
    chk("midrst_done", 32'(bus.Done), 32'd0);
    chk("midrst_mb_en", 32'(bus.MB_en), 32'd0);
    Rst = 1'b0;
    repeat (3) tick();
    chk("midrst_idle_mp_en", 32'(bus.MP_en), 32'd0);
    chk("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    push_range(8'h80, 1'b0, 0, 4 * NW);
    go(8'h80, 1'b0, t0);
    wait_done(t0, "after_rst");

    // Done holds in FIN, then restart with Thr=FE
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("fin_hold_done", 32'(bus.Done), 32'd1);
    end
    randomize_mem();
    mem_p[0] = 32'hFFFEFF00;
    mem_p[1] = 32'hFEFFFFFE;
    push_lit(0, 8'hFF); push_lit(1, 8'h00); push_lit(2, 8'hFF); push_lit(3, 8'h00);
    push_lit(4, 8'h00); push_lit(5, 8'hFF); push_lit(6, 8'hFF); push_lit(7, 8'h00);
    push_range(8'hFE, 1'b0, 8, 4 * NW);
    go(8'hFE, 1'b0, t0);
    chk("thr_fe_done_drop", 32'(bus.Done), 32'd0);
    wait_done(t0, "thr_fe");

`ifdef THRESH_INVERT_EN
    randomize_mem();
    mem_p[0] = 32'h7F80007F;
    push_lit(0, 8'hFF); push_lit(1, 8'h00); push_lit(2, 8'hFF); push_lit(3, 8'hFF);
    push_range(8'h7F, 1'b1, 4, 4 * NW);
    go(8'h7F, 1'b1, t0);
    wait_done(t0, "invert");
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
